mips_main_control: RTL

- Multi-cycle main control FSM for the MIPS core.
- Decodes the instruction opcode and sequences datapath enables over fetch/decode/execute/memory/writeback cycles.
- Drives the 2-bit aluop consumed by the ALU control decoder (00 R-type via func, 01 add, 10 branch compare, 11 OR-immediate).
- Stalls on a memory ready handshake and flags illegal opcodes.

---
 rtl/mips_main_control.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mips_main_control.sv
// Multi-cycle MIPS main control FSM: decodes the opcode and sequences datapath
// enables across fetch/decode/execute/memory/writeback, stalling on mem_ready.
module mips_main_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [1:0]         aluop,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [STATE_W-1:0] {
    S_RST_IDLE = STATE_W'(0),
    S_FETCH    = STATE_W'(1),
    S_DECODE   = STATE_W'(2),
    S_MEM_ADDR = STATE_W'(3),
    S_MEM_RD   = STATE_W'(4),
    S_MEM_WB   = STATE_W'(5),
    S_MEM_WR   = STATE_W'(6),
    S_R_EXEC   = STATE_W'(7),
    S_R_WB     = STATE_W'(8),
    S_BRANCH   = STATE_W'(9),
    S_JUMP     = STATE_W'(10),
    S_IMM_EXEC = STATE_W'(11),
    S_IMM_WB   = STATE_W'(12)
  } state_e;

  state_e state_q, state_d;
  logic   mem_rdy;

  // With waits disabled every memory access completes in one cycle.
  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state   = state_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output and state_d gets a default first, so no path through
    // the case below leaves a signal unassigned and no latch is inferred.
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    aluop         = 2'b00;
    illegal_op    = 1'b0;

    unique case (state_q)
      S_RST_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        aluop     = 2'b01;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        aluop     = 2'b01;
        unique case (opcode)
          OP_R:            state_d = S_R_EXEC;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_IMM_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop     = 2'b01;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b10;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop     = (opcode == OP_ORI) ? 2'b11 : 2'b01;
        state_d   = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_RST_IDLE;
    endcase
  end

endmodule
